// File: rtl/falu_arbiter.sv
// Shares one combinational falu between NREQ requesters, holding operands for WAIT_CYC cycles.
// Define FALU_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration; default is round-robin.
module falu_arbiter #(
    parameter int NREQ     = 4,
    parameter int WAIT_CYC = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [2*NREQ-1:0]       req_op,
    input  logic [32*NREQ-1:0]      req_b,
    input  logic [32*NREQ-1:0]      req_c,
    output logic [1:0]              alu_op,
    output logic [31:0]             alu_b,
    output logic [31:0]             alu_c,
    input  logic [31:0]             alu_out,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [31:0]             rsp_data,
    output logic                    busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t         state, state_next;
    logic [CW-1:0]  cnt;
    logic           found;
    logic [IDW-1:0] gnt_idx;
    logic           accept;

`ifdef FALU_ARB_FIXED_PRIO_EN
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && req_valid[k]) begin
                found   = 1'b1;
                gnt_idx = IDW'(k);
            end
        end
    end
`else
    logic [IDW-1:0] rr_ptr;
    int unsigned    idx;

    // Search starts at rr_ptr and wraps, so the last winner is checked last.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(rr_ptr) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end
`endif

    assign accept = (state == IDLE) && found;
    assign busy   = (state != IDLE);

    always_comb begin
        req_ready = '0;
        if (state == IDLE && found && !rst) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    if (cnt == '0) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_op    <= '0;
            alu_b     <= '0;
            alu_c     <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            if (accept) begin
                alu_op <= req_op[2*gnt_idx +: 2];
                alu_b  <= req_b[32*gnt_idx +: 32];
                alu_c  <= req_c[32*gnt_idx +: 32];
                rsp_id <= gnt_idx;
                cnt    <= CNT_LOAD;
            end
            if (state == EXEC) begin
                if (cnt == '0) begin
                    rsp_data  <= alu_out;
                    rsp_valid <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_falu_arbiter.sv
// Self-checking bench for falu_arbiter: timeline reference model plus directed and random traffic.
module tb_falu_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 2;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [2*NREQ-1:0]    req_op = '0;
    logic [32*NREQ-1:0]   req_b = '0;
    logic [32*NREQ-1:0]   req_c = '0;
    logic [1:0]           alu_op;
    logic [31:0]          alu_b, alu_c, alu_out;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_data;
    logic                 busy;

    logic [NREQ-1:0]      s_valid = '0;
    logic [NREQ-1:0]      s1_ready, s4_ready;
    logic [1:0]           s1_op, s4_op;
    logic [31:0]          s1_b, s1_c, s1_out, s1_data, s4_b, s4_c, s4_out, s4_data;
    logic                 s1_rv, s1_busy, s4_rv, s4_busy;
    logic [IDW-1:0]       s1_id, s4_id;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    int gnt_log[$];
    int gnt_cyc[$];
    int rv_cyc[$];
    logic [33:0] resp_log[$];
    int s1_t[$];
    int s4_t[$];

    // Stand-in for falu: exact IEEE results for the vectors used, a scrambling function otherwise.
    function automatic logic [31:0] fake_falu(input logic [1:0] op, input logic [31:0] b, input logic [31:0] c);
        case ({op, b, c})
            {2'b00, 32'h3f800000, 32'h40000000}: return 32'h40400000;
            {2'b10, 32'h40000000, 32'h40400000}: return 32'h40c00000;
            {2'b01, 32'h40400000, 32'h3f800000}: return 32'h40000000;
            {2'b11, 32'h40400000, 32'h40000000}: return 32'h3fc00000;
            default: return (b ^ {c[15:0], c[31:16]}) + {30'd0, op} * 32'h01000193;
        endcase
    endfunction

    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
        int start;
        start = ptr;
`ifdef FALU_ARB_FIXED_PRIO_EN
        start = 0;
`endif
        for (int k = 0; k < NREQ; k++) begin
            if (v[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    assign alu_out = fake_falu(alu_op, alu_b, alu_c);
    assign s1_out  = fake_falu(s1_op, s1_b, s1_c);
    assign s4_out  = fake_falu(s4_op, s4_b, s4_c);

    falu_arbiter #(.NREQ(NREQ), .WAIT_CYC(W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_b(req_b), .req_c(req_c),
        .alu_op(alu_op), .alu_b(alu_b), .alu_c(alu_c), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy)
    );

    falu_arbiter #(.NREQ(NREQ), .WAIT_CYC(1)) dut_w1 (
        .clk(clk), .rst(rst), .req_valid(s_valid), .req_ready(s1_ready),
        .req_op(req_op), .req_b(req_b), .req_c(req_c),
        .alu_op(s1_op), .alu_b(s1_b), .alu_c(s1_c), .alu_out(s1_out),
        .rsp_valid(s1_rv), .rsp_ready(1'b1), .rsp_id(s1_id),
        .rsp_data(s1_data), .busy(s1_busy)
    );

    falu_arbiter #(.NREQ(NREQ), .WAIT_CYC(4)) dut_w4 (
        .clk(clk), .rst(rst), .req_valid(s_valid), .req_ready(s4_ready),
        .req_op(req_op), .req_b(req_b), .req_c(req_c),
        .alu_op(s4_op), .alu_b(s4_b), .alu_c(s4_c), .alu_out(s4_out),
        .rsp_valid(s4_rv), .rsp_ready(1'b1), .rsp_id(s4_id),
        .rsp_data(s4_data), .busy(s4_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference model: one operation in flight, accepted at edge m_acc, result due W edges later.
    bit          m_busy = 1'b0;
    logic [1:0]  m_op = '0;
    logic [31:0] m_b = '0, m_c = '0, m_res = '0, m_last = '0;
    int          m_id = 0, m_rr = 0, m_t = 0, m_acc = 0, mg = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0; m_op = '0; m_b = '0; m_c = '0;
            m_res = '0; m_last = '0; m_id = 0; m_rr = 0;
        end else begin
            if (!m_busy) begin
                mg = pick(req_valid, m_rr);
                if (mg >= 0) begin
                    m_busy = 1'b1;
                    m_id   = mg;
                    m_op   = req_op[2*mg +: 2];
                    m_b    = req_b[32*mg +: 32];
                    m_c    = req_c[32*mg +: 32];
                    m_res  = fake_falu(m_op, m_b, m_c);
                    m_acc  = m_t + 1;
                    m_rr   = (mg + 1) % NREQ;
                end
            end else if (m_t >= m_acc + W && rsp_ready) begin
                m_busy = 1'b0;
                m_last = m_res;
            end
            m_t++;
        end
    end

    logic            exp_rv, prev_rv = 1'b0;
    logic [NREQ-1:0] exp_rdy;
    int              cg;

    always @(negedge clk) begin
        if (chk_en) begin
            exp_rv  = m_busy && (m_t >= m_acc + W);
            exp_rdy = '0;
            if (!rst && !m_busy) begin
                cg = pick(req_valid, m_rr);
                if (cg >= 0) exp_rdy[cg] = 1'b1;
            end
            check("req_ready", req_ready, exp_rdy);
            check("busy", busy, m_busy);
            check("rsp_valid", rsp_valid, exp_rv);
            check("rsp_id", rsp_id, m_id);
            check("rsp_data", rsp_data, exp_rv ? m_res : m_last);
            check("alu_op", alu_op, m_op);
            check("alu_bc", {alu_b, alu_c}, {m_b, m_c});

            for (int i = 0; i < NREQ; i++) begin
                if (!rst && req_ready[i] && req_valid[i]) begin
                    gnt_log.push_back(i);
                    gnt_cyc.push_back(cyc);
                end
            end
            if (rsp_valid && !prev_rv) rv_cyc.push_back(cyc);
            prev_rv = rsp_valid;
            if (rsp_valid && rsp_ready) resp_log.push_back({rsp_id, rsp_data});
            if (s1_ready[1]) s1_t.push_back(cyc);
            if (s4_ready[1]) s4_t.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] b, input logic [31:0] c);
        req_op[2*i +: 2]  = op;
        req_b[32*i +: 32] = b;
        req_c[32*i +: 32] = c;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; s_valid = '0;
        tick();
        rst = 1'b0;
        gnt_log.delete(); gnt_cyc.delete(); rv_cyc.delete(); resp_log.delete();
        s1_t.delete(); s4_t.delete();
    endtask

    logic [31:0] rr_exp [4] = '{32'h40400000, 32'h40c00000, 32'h40000000, 32'h3fc00000};
    int          fair_exp[4];
    logic [31:0] rb, rc;

    initial begin
        #1 rst = 1'b1;
        #1 chk_en = 1'b1;
        do_reset();

        // Round-robin from reset; each requester drops its request once granted.
        set_req(0, 2'b00, 32'h3f800000, 32'h40000000);
        set_req(1, 2'b10, 32'h40000000, 32'h40400000);
        set_req(2, 2'b01, 32'h40400000, 32'h3f800000);
        set_req(3, 2'b11, 32'h40400000, 32'h40000000);
        req_valid = '1; rsp_ready = 1'b1;
        for (int i = 0; i < 60 && gnt_log.size() < 4; i++) begin
            tick();
            foreach (gnt_log[j]) req_valid[gnt_log[j]] = 1'b0;
        end
        req_valid = '0;
        for (int i = 0; i < 20 && resp_log.size() < 4; i++) tick();
        check("rr_ngnt", gnt_log.size(), 4);
        check("rr_nresp", resp_log.size(), 4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++) check($sformatf("rr_gnt%0d", i), gnt_log[i], i);
        for (int i = 0; i < 4 && i < resp_log.size(); i++)
            check($sformatf("rr_resp%0d", i), resp_log[i], {2'(i), rr_exp[i]});

        // Single ADD from requester 1, held valid to measure accept-to-accept spacing.
        do_reset();
        set_req(1, 2'b00, 32'h3f800000, 32'h40000000);
        req_valid = 4'b0010; rsp_ready = 1'b1;
        for (int i = 0; i < 40 && gnt_log.size() < 2; i++) tick();
        req_valid = '0;
        for (int i = 0; i < 20 && resp_log.size() < 2; i++) tick();
        check("add_ngnt", gnt_log.size(), 2);
        check("add_nrise", rv_cyc.size() >= 1, 1);
        if (gnt_log.size() >= 2) check("add_period", gnt_cyc[1] - gnt_cyc[0], 4);
        if (rv_cyc.size() >= 1 && gnt_cyc.size() >= 1) check("add_latency", rv_cyc[0] - (gnt_cyc[0] + 1), W);
        if (resp_log.size() >= 1) check("add_resp", resp_log[0], {2'd1, 32'h40400000});

        // Fairness between requesters 0 and 2.
        do_reset();
        set_req(0, 2'b10, $urandom, $urandom);
        set_req(2, 2'b01, $urandom, $urandom);
        req_valid = 4'b0101; rsp_ready = 1'b1;
        for (int i = 0; i < 60 && gnt_log.size() < 4; i++) tick();
        req_valid = '0;
        for (int i = 0; i < 20 && busy; i++) tick();
`ifdef FALU_ARB_FIXED_PRIO_EN
        fair_exp = '{0, 0, 0, 0};
`else
        fair_exp = '{0, 2, 0, 2};
`endif
        check("fair_ngnt", gnt_log.size(), 4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++) check($sformatf("fair_gnt%0d", i), gnt_log[i], fair_exp[i]);

        // Backpressure: five stalled cycles with other requesters waiting.
        do_reset();
        set_req(2, 2'b11, $urandom, $urandom);
        req_valid = 4'b0100; rsp_ready = 1'b0;
        for (int i = 0; i < 20 && gnt_log.size() < 1; i++) tick();
        req_valid = 4'b1011;
        for (int i = 0; i < 20 && rv_cyc.size() < 1; i++) tick();
        repeat (5) tick();
        req_valid = '0; rsp_ready = 1'b1;
        repeat (4) tick();
        check("bp_ngnt", gnt_log.size(), 1);
        check("bp_nresp", resp_log.size(), 1);
        if (resp_log.size() >= 1) check("bp_id", resp_log[0][33:32], 2);

        // Reset one cycle after acceptance aborts the operation.
        do_reset();
        rb = $urandom | 32'h1; rc = $urandom | 32'h1;
        set_req(3, 2'b10, rb, rc);
        req_valid = 4'b1000; rsp_ready = 1'b1;
        for (int i = 0; i < 20 && gnt_log.size() < 1; i++) tick();
        req_valid = '0;
        tick();
        rst = 1'b1;
        #1;
        check("rst_alu_bc", {alu_b, alu_c}, 64'd0);
        check("rst_misc", {req_ready, alu_op, rsp_valid, rsp_id, busy, rsp_data}, 64'd0);
        tick();
        rst = 1'b0;
        repeat (6) tick();
        check("rst_nresp", resp_log.size(), 0);
        req_valid = 4'b1000;
        for (int i = 0; i < 20 && gnt_log.size() < 2; i++) tick();
        req_valid = '0;
        for (int i = 0; i < 20 && resp_log.size() < 1; i++) tick();
        check("rst_fresh_n", resp_log.size(), 1);
        if (resp_log.size() >= 1) check("rst_fresh", resp_log[0], {2'd3, fake_falu(2'b10, rb, rc)});

        // Random traffic: requests may come and go, consumer stalls at random.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req_valid = NREQ'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            req_op    = 8'($urandom);
            req_b     = {$urandom, $urandom, $urandom, $urandom};
            req_c     = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        req_valid = '0; rsp_ready = 1'b1;
        repeat (8) tick();

        // Back-to-back MUL on the WAIT_CYC=1 and WAIT_CYC=4 instances.
        do_reset();
        set_req(1, 2'b10, 32'h40000000, 32'h40400000);
        s_valid = 4'b0010;
        for (int i = 0; i < 60 && s4_t.size() < 3; i++) tick();
        s_valid = '0;
        check("w1_n", s1_t.size() >= 2, 1);
        check("w4_n", s4_t.size() >= 3, 1);
        if (s1_t.size() >= 2) check("w1_period", s1_t[1] - s1_t[0], 3);
        if (s4_t.size() >= 3) begin
            check("w4_period0", s4_t[1] - s4_t[0], 6);
            check("w4_period1", s4_t[2] - s4_t[1], 6);
        end
        repeat (8) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/falu_arbiter.md
# falu_arbiter

Shares one combinational floating-point ALU (`falu`: 2-bit op ADD=00, SUB=01, MUL=10, DIV=11; 32-bit operands b, c; 32-bit result) between NREQ requesters. The arbiter holds the selected operands stable on the ALU inputs for a programmable number of cycles, treating the ALU as a multicycle path. It then registers the result and returns it with the requester's index. It sits between the neuron-update sequencers and the single shared `falu` instance.

## Interface
- NREQ, 4, number of requesters; legal range 2..16
- WAIT_CYC, 2, cycles operands are held on the ALU before the result is sampled; ≥1
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_ready  out  NREQ  one-hot grant/accept
- req_op  in  2*NREQ  op of requester i at [2i+1:2i]
- req_b  in  32*NREQ  operand b of requester i at [32i+31:32i]
- req_c  in  32*NREQ  operand c of requester i at [32i+31:32i]
- alu_op  out  2  to falu op
- alu_b  out  32  to falu b
- alu_c  out  32  to falu c
- alu_out  in  32  from falu result
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  $clog2(NREQ)  index of requester owning rsp_data
- rsp_data  out  32  registered ALU result
- busy  out  1  high in EXEC or RESP

## Operation
- Reset values: req_ready=0, alu_op=0, alu_b=0, alu_c=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, state=IDLE, rr pointer=0, counter=0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Arbitrate among req_valid. req_ready is combinational and one-hot, asserted only for the winner g, and only in IDLE. All zeros if no request is valid.
  - On the edge with req_valid[g]&&req_ready[g]: latch req_op/b/c of g into alu_op/b/c and g into rsp_id. Load counter=WAIT_CYC-1. Set rr pointer=(g+1) mod NREQ. Go to EXEC.
- EXEC:
  - alu_* are held constant.
  - On the edge where counter==0: rsp_data<=alu_out, rsp_valid<=1, go to RESP.
  - Otherwise counter decrements.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held until the rsp_valid&&rsp_ready edge. At that edge rsp_valid<=0 and state goes to IDLE.
  - No new request is accepted in EXEC or RESP; req_ready stays all zero.
- Round-robin arbitration: search from the rr pointer upward, wrapping at NREQ-1→0. The first requester with valid set wins.
- alu_* keep their last values after an operation; they are not cleared.
- Ops are passed through unmodified. Division by zero and NaN/Inf handling belong to falu; the arbiter returns whatever falu produces.
- A requester may drop req_valid before it is granted; nothing is recorded for it.
- Asserting rst in any state aborts the in-flight operation. No response is produced for it, and all registers take their reset values immediately.

## Timing
- Accept at edge T. alu_* are valid from T. Result is sampled at edge T+WAIT_CYC. rsp_valid is high from T+WAIT_CYC.
- Earliest response handshake is at edge T+WAIT_CYC+1 (rsp_ready held high). Earliest next accept is at edge T+WAIT_CYC+2.
- Peak throughput is one operation per WAIT_CYC+2 cycles.
- rsp_ready low in RESP stalls indefinitely. Outputs stay stable and no grant is issued.
- req_valid and rsp_ready may change in the same cycle as the RESP→IDLE transition. Arbitration uses the post-transition state, so the first grant is in the following cycle.

## Configuration
- FALU_ARB_FIXED_PRIO_EN defined: fixed priority. Lowest index wins, and the rr pointer is not implemented.
- FALU_ARB_FIXED_PRIO_EN undefined (default): round-robin as specified above.

## Test plan
- Single ADD, NREQ=4, WAIT_CYC=2. Req 1 sends op=00, b=3f800000, c=40000000.
  - Required: accept at edge T, rsp_valid from T+2, rsp_id=1, rsp_data=40400000.
  - Required: rsp_ready high gives next req_ready at T+4.
- Round-robin, all four valid from reset. Ops: req0 ADD 3f800000+40000000, req1 MUL 40000000*40400000, req2 SUB 40400000-3f800000, req3 DIV 40400000/40000000.
  - Required: grants in order 0,1,2,3.
  - Required: responses 40400000, 40c00000, 40000000, 3fc00000 with matching rsp_id.
- Fairness: req0 and req2 continuously valid.
  - Required: grants alternate 0,2,0,2; req0 never wins twice in a row.
  - With FALU_ARB_FIXED_PRIO_EN defined: req0 always wins.
- Backpressure: rsp_ready held low 5 cycles after rsp_valid rises.
  - Required: rsp_valid, rsp_data and rsp_id are stable, req_ready is 0 throughout, and exactly one response is delivered.
- Reset mid-EXEC: assert rst one cycle after acceptance.
  - Required: all outputs are 0 immediately, no response appears, and a fresh request afterwards completes normally.
- WAIT_CYC=1 vs WAIT_CYC=4 back-to-back MUL requests with rsp_ready always high.
  - Required: accept-to-accept period of 3 and 6 cycles respectively.
